// File: rtl/core_pipe_decode_stage_pkg.sv
// Shared constants and types for the decode front half.
// Holds the default widths and the length-encoding opcode fields.
// Imported by the decode stage and its length-decode lane.
package core_pipe_decode_stage_pkg;

  // Default widths: address, fetch window, fetch-error halfwords.
  localparam int XL        = 64;
  localparam int FD_IBUF_R = 32;
  localparam int FD_ERR_R  = 2;

  // Low two bits of a 32-bit (or longer) encoding.
  localparam logic [1:0] DEC_OPC_32    = 2'b11;
  // Bits [4:2] value that marks a 48-bit-or-longer encoding.
  localparam logic [2:0] DEC_LONG_MASK = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } dec_state_e;

endpackage

// File: rtl/core_pipe_decode_len.sv
// Instruction length decode for one lane: 16/32-bit and illegal long encodings.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the instruction is consumed.
module core_pipe_decode_len
  import core_pipe_decode_stage_pkg::*;
#(
  parameter int C_EN = 1
) (
  input  logic [4:0] instr,
  input  logic       ferr0,
  output logic       long_enc,
  output logic       need4,
  output logic       illegal
);

  logic is32;

  // A fetch error on the first halfword makes the length bits meaningless,
  // so the packet is handled as a 16-bit error packet with no long flag.
  always_comb begin
    is32     = (instr[1:0] == DEC_OPC_32);
    long_enc = is32 && (instr[4:2] == DEC_LONG_MASK) && !ferr0;
    need4    = is32 && !long_enc && !ferr0;
    illegal  = long_enc || (!need4 && !ferr0 && (C_EN == 0));
  end

endmodule

// File: rtl/core_pipe_decode_stage.sv
// Decode front half: sizes the head instruction, tells fetch what to eat, fills the stage-2 slot.
// Latency: 1 cycle from fire (eat) to s2_valid; one instruction per cycle with s2_ready high.
// Backpressure: slot holds while s2_valid && !s2_ready; halts after a faulting packet until s2_flush.
module core_pipe_decode_stage
  import core_pipe_decode_stage_pkg::*;
#(
  parameter int XLEN   = XL,
  parameter int IBUF_W = FD_IBUF_R,
  parameter int ERR_W  = FD_ERR_R,
  parameter int C_EN   = 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              s1_avail_2,
  input  logic              s1_avail_4,
  input  logic [IBUF_W-1:0] s1_instr,
  input  logic [XLEN-1:0]   s1_pc,
  input  logic [ERR_W-1:0]  s1_ferr,
  output logic              s2_eat_2,
  output logic              s2_eat_4,
  input  logic              s2_flush,
  input  logic              s2_ready,
  output logic              s2_valid,
  output logic [31:0]       s2_instr,
  output logic [XLEN-1:0]   s2_pc,
  output logic [XLEN-1:0]   s2_npc,
  output logic              s2_size32,
  output logic              s2_ferr,
  output logic              s2_illegal
);

  logic            long_enc, need4, len_illegal;
  logic            slot_free, have, fire;
  logic            pkt_ferr, pkt_illegal;
  logic [31:0]     pkt_instr;
  logic [XLEN-1:0] pkt_step;

  logic            valid_q,   valid_d;
  logic [31:0]     instr_q,   instr_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] npc_q,     npc_d;
  logic            size32_q,  size32_d;
  logic            ferr_q,    ferr_d;
  logic            illegal_q, illegal_d;
  dec_state_e      state_q,   state_d;

  core_pipe_decode_len #(.C_EN(C_EN)) u_len (
    .instr    (s1_instr[4:0]),
    .ferr0    (s1_ferr[0]),
    .long_enc (long_enc),
    .need4    (need4),
    .illegal  (len_illegal)
  );

  // Handshake: fire when the slot can take a packet and fetch has enough bytes.
  always_comb begin
    slot_free   = !valid_q || s2_ready;
    have        = need4 ? s1_avail_4 : s1_avail_2;
    fire        = slot_free && have && (state_q == ST_RUN) && !s2_flush;
    s2_eat_4    = fire && need4;
    s2_eat_2    = fire && !need4;
    pkt_instr   = need4 ? s1_instr[31:0] : {16'b0, s1_instr[15:0]};
    pkt_step    = need4 ? XLEN'(4) : XLEN'(2);
    pkt_ferr    = s1_ferr[0] | (need4 & s1_ferr[1]);
    pkt_illegal = len_illegal;
  end

  // Next slot contents and run/halt state; flush beats any fire or drain.
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    size32_d  = size32_q;
    ferr_d    = ferr_q;
    illegal_d = illegal_q;
    state_d   = state_q;
    if (s2_flush) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (fire) begin
      valid_d   = 1'b1;
      instr_d   = pkt_instr;
      pc_d      = s1_pc;
      npc_d     = s1_pc + pkt_step;
      size32_d  = need4;
      ferr_d    = pkt_ferr;
      illegal_d = pkt_illegal;
      // The faulting packet still issues; nothing after it is consumed.
      if (pkt_ferr || pkt_illegal) state_d = ST_HALT;
    end else if (slot_free) begin
      valid_d = 1'b0;
    end
  end

  // Stage-2 slot and state registers with synchronous reset.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      npc_q     <= '0;
      size32_q  <= 1'b0;
      ferr_q    <= 1'b0;
      illegal_q <= 1'b0;
      state_q   <= ST_RUN;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      size32_q  <= size32_d;
      ferr_q    <= ferr_d;
      illegal_q <= illegal_d;
      state_q   <= state_d;
    end
  end

  assign s2_valid   = valid_q;
  assign s2_instr   = instr_q;
  assign s2_pc      = pc_q;
  assign s2_npc     = npc_q;
  assign s2_size32  = size32_q;
  assign s2_ferr    = ferr_q;
  assign s2_illegal = illegal_q;

endmodule

// File: tb/tb_core_pipe_decode_stage.sv
// Bench for core_pipe_decode_stage: two instances (compressed legal / illegal) on shared stimulus,
// directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_core_pipe_decode_stage;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        a2, a4, flush, ready;
  logic [31:0] instr;
  logic [63:0] pc;
  logic [1:0]  ferr;

  logic        eat2 [2];
  logic        eat4 [2];
  logic        vld  [2];
  logic        sz   [2];
  logic        fe   [2];
  logic        il   [2];
  logic [31:0] oi   [2];
  logic [63:0] opc  [2];
  logic [63:0] onpc [2];

  always #5 g_clk = ~g_clk;

  core_pipe_decode_stage #(.XLEN(64), .IBUF_W(32), .ERR_W(2), .C_EN(1)) dut0 (
    .g_clk(g_clk), .g_resetn(g_resetn), .s1_avail_2(a2), .s1_avail_4(a4),
    .s1_instr(instr), .s1_pc(pc), .s1_ferr(ferr),
    .s2_eat_2(eat2[0]), .s2_eat_4(eat4[0]), .s2_flush(flush), .s2_ready(ready),
    .s2_valid(vld[0]), .s2_instr(oi[0]), .s2_pc(opc[0]), .s2_npc(onpc[0]),
    .s2_size32(sz[0]), .s2_ferr(fe[0]), .s2_illegal(il[0])
  );

  core_pipe_decode_stage #(.XLEN(64), .IBUF_W(32), .ERR_W(2), .C_EN(0)) dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .s1_avail_2(a2), .s1_avail_4(a4),
    .s1_instr(instr), .s1_pc(pc), .s1_ferr(ferr),
    .s2_eat_2(eat2[1]), .s2_eat_4(eat4[1]), .s2_flush(flush), .s2_ready(ready),
    .s2_valid(vld[1]), .s2_instr(oi[1]), .s2_pc(opc[1]), .s2_npc(onpc[1]),
    .s2_size32(sz[1]), .s2_ferr(fe[1]), .s2_illegal(il[1])
  );

  int errs   = 0;
  int checks = 0;

  // Behavioural model state, one entry per instance.
  bit          mv   [2];
  bit          mh   [2];
  bit          msz  [2];
  bit          mfe  [2];
  bit          mil  [2];
  logic [31:0] mi   [2];
  logic [63:0] mpc  [2];
  logic [63:0] mnpc [2];
  int          cen  [2] = '{1, 0};
  // Eat outputs observed in the last step, for literal checks.
  bit          cap_e2 [2];
  bit          cap_e4 [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, check eats against the model, clock, check the slot.
  task automatic step(input logic [31:0] i_ins, input logic [63:0] i_pc, input logic i_a2,
                      input logic i_a4, input logic [1:0] i_fe, input logic i_rdy,
                      input logic i_fl);
    int  len;
    bit  is_long, is_err16, fire [2], illg [2];
    @(negedge g_clk);
    instr = i_ins; pc = i_pc; a2 = i_a2; a4 = i_a4; ferr = i_fe; ready = i_rdy; flush = i_fl;
    #1;
    // Packet length in bytes as fetch sees it; long encodings consume one halfword.
    is_err16 = i_fe[0];
    is_long  = !is_err16 && i_ins[1:0] == 2'd3 && i_ins[4:2] == 3'd7;
    len      = (!is_err16 && !is_long && i_ins[1:0] == 2'd3) ? 4 : 2;
    for (int l = 0; l < 2; l++) begin
      illg[l] = is_long || (!is_err16 && len == 2 && cen[l] == 0);
      fire[l] = (!mv[l] || i_rdy) && (len == 4 ? i_a4 : i_a2) && !mh[l] && !i_fl;
      cap_e2[l] = eat2[l];
      cap_e4[l] = eat4[l];
      if (g_resetn) begin
        chk($sformatf("L%0d eat4", l), eat4[l], fire[l] && len == 4);
        chk($sformatf("L%0d eat2", l), eat2[l], fire[l] && len == 2);
      end
    end
    @(posedge g_clk);
    for (int l = 0; l < 2; l++) begin
      if (!g_resetn) begin
        mv[l] = 0; mh[l] = 0; msz[l] = 0; mfe[l] = 0; mil[l] = 0;
        mi[l] = 0; mpc[l] = 0; mnpc[l] = 0;
      end else if (i_fl) begin
        mv[l] = 0; mh[l] = 0;
      end else if (fire[l]) begin
        mv[l]   = 1;
        mi[l]   = (len == 4) ? i_ins : (i_ins & 32'h0000_FFFF);
        mpc[l]  = i_pc;
        mnpc[l] = i_pc + 64'(len);
        msz[l]  = (len == 4);
        mfe[l]  = i_fe[0] || (len == 4 && i_fe[1]);
        mil[l]  = illg[l];
        if (mfe[l] || mil[l]) mh[l] = 1;
      end else if (i_rdy) begin
        mv[l] = 0;
      end
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("L%0d valid", l),   vld[l],  mv[l]);
      chk($sformatf("L%0d instr", l),   oi[l],   mi[l]);
      chk($sformatf("L%0d pc", l),      opc[l],  mpc[l]);
      chk($sformatf("L%0d npc", l),     onpc[l], mnpc[l]);
      chk($sformatf("L%0d size32", l),  sz[l],   msz[l]);
      chk($sformatf("L%0d ferr", l),    fe[l],   mfe[l]);
      chk($sformatf("L%0d illegal", l), il[l],   mil[l]);
    end
  endtask

  initial begin
    logic [31:0] r_ins;
    logic [63:0] r_pc;
    logic        r_a2;
    g_resetn = 1'b0;
    instr = 0; pc = 0; a2 = 0; a4 = 0; ferr = 0; ready = 0; flush = 0;

    // Reset state.
    step(32'h0, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step(32'h0, 64'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("rst valid0", vld[0], 1'b0);
    chk("rst valid1", vld[1], 1'b0);
    chk("rst npc0",   onpc[0], 64'h0);
    g_resetn = 1'b1;

    // 32-bit addi, full window.
    step(32'h0000_0013, 64'h1000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("t1 eat4", cap_e4[0], 1'b1);
    chk("t1 valid", vld[0], 1'b1);
    chk("t1 instr", oi[0], 32'h13);
    chk("t1 npc", onpc[0], 64'h1004);
    chk("t1 size32", sz[0], 1'b1);

    // c.li with only two bytes; illegal on the C_EN=0 instance, which then halts.
    step(32'hABCD_4501, 64'h2000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("c16 eat2", cap_e2[0], 1'b1);
    chk("c16 instr", oi[0], 32'h0000_4501);
    chk("c16 npc", onpc[0], 64'h2002);
    chk("c16 legal", il[0], 1'b0);
    chk("c16 noc illegal", il[1], 1'b1);
    step(32'h0000_4501, 64'h2002, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("noc halted eat", cap_e2[1], 1'b0);
    chk("c16 again eat2", cap_e2[0], 1'b1);

    // 32-bit instruction without enough bytes, then bytes arrive.
    step(32'h0000_0013, 64'h3000, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("short eat4", cap_e4[0], 1'b0);
    chk("short eat2", cap_e2[0], 1'b0);
    chk("short valid", vld[0], 1'b0);
    step(32'h0000_0013, 64'h3000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("bytes eat4", cap_e4[0], 1'b1);

    // Stall for three cycles, then release.
    for (int k = 0; k < 3; k++) begin
      step(32'h0000_4501, 64'h4000, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
      chk("stall eat", cap_e2[0], 1'b0);
      chk("stall pc", opc[0], 64'h3000);
    end
    step(32'h0000_4501, 64'h4000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("release eat2", cap_e2[0], 1'b1);
    chk("release pc", opc[0], 64'h4000);

    // Fetch error on the upper halfword of a 32-bit instruction.
    step(32'h0000_0013, 64'h5000, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
    chk("ferr eat4", cap_e4[0], 1'b1);
    chk("ferr flag", fe[0], 1'b1);
    step(32'h0000_0013, 64'h5004, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("halt eat4", cap_e4[0], 1'b0);
    chk("halt valid", vld[0], 1'b0);
    step(32'h0000_0013, 64'h6000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    chk("flush eat4", cap_e4[0], 1'b0);
    chk("flush valid", vld[0], 1'b0);
    step(32'h0000_0013, 64'h6000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("post flush eat4", cap_e4[0], 1'b1);

    // PC wrap.
    step(32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("wrap npc", onpc[0], 64'h2);

    // 48-bit-or-longer encoding.
    step(32'h0000_001F, 64'h7000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("long eat2", cap_e2[0], 1'b1);
    chk("long illegal", il[0], 1'b1);
    chk("long npc", onpc[0], 64'h7002);

    // Flush beats a fire that would otherwise happen.
    step(32'h0000_0013, 64'h8000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    step(32'h0000_0013, 64'h8000, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
    chk("pre flush valid", vld[0], 1'b1);
    step(32'h0000_0013, 64'h8004, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1);
    chk("flush wins eat4", cap_e4[0], 1'b0);
    chk("flush wins eat2", cap_e2[0], 1'b0);
    chk("flush wins valid", vld[0], 1'b0);

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      g_resetn = ($urandom % 250) != 0;
      r_ins = $urandom;
      if ($urandom % 2 == 0) r_ins[1:0] = 2'b11;
      r_pc = {32'($urandom), 32'($urandom)};
      if ($urandom % 32 == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom % 4);
      r_a2 = ($urandom % 8) != 0;
      step(r_ins, r_pc, r_a2, r_a2 && ($urandom % 2 == 0),
           ($urandom % 10 == 0) ? 2'($urandom) : 2'b00,
           ($urandom % 4) != 0, ($urandom % 16) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
